// File: rtl/udcnt_pkg.sv
// Shared definitions for the up/down counter SFR: count mode constants and
// the per-edge operation encoding produced by the priority decode.
package udcnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

endpackage : udcnt_pkg

// File: rtl/udcnt_next.sv
// Next-count datapath: step arithmetic against the registered limit, with
// wrap/saturate handling and overflow/underflow event strobes. Purely combinational.
module udcnt_next
  import udcnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  limit_q,
  input  logic [STEP_W-1:0] step,
  input  op_e               op,
  input  logic              mode_sat,
  output logic [WIDTH-1:0]  q_next,
  output logic              ovf_set,
  output logic              unf_set
);

  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;

  // One extra bit so q + step never aliases back below the limit.
  assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum    = {1'b0, q} + step_x;

  always_comb begin
    q_next  = q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_UP: begin
        if (sum <= {1'b0, limit_q}) begin
          q_next = sum[WIDTH-1:0];
        end else begin
          ovf_set = 1'b1;
          q_next  = (mode_sat == MODE_SAT) ? limit_q : '0;
        end
      end
      OP_DOWN: begin
        if (step_x <= {1'b0, q}) begin
          q_next = q - step_x[WIDTH-1:0];
        end else begin
          unf_set = 1'b1;
          q_next  = (mode_sat == MODE_SAT) ? '0 : limit_q;
        end
      end
      default: begin
        q_next = q;
      end
    endcase
  end

endmodule : udcnt_next

// File: rtl/ud_counter_sfr_gen.sv
// Up/down counter SFR with programmable step and limit, wrap/saturate, terminal
// counts and sticky flags. Optional capture register under UDCNT_CAPTURE_EN.
module ud_counter_sfr_gen
  import udcnt_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic [WIDTH-1:0]  d,
  input  logic              incr,
  input  logic              decr,
  input  logic [STEP_W-1:0] step,
  input  logic              limit_ld,
  input  logic [WIDTH-1:0]  limit_d,
  input  logic              mode_sat,
  input  logic              flag_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  limit_q,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ovf,
  output logic              unf
`ifdef UDCNT_CAPTURE_EN
  ,
  input  logic              cap,
  output logic [WIDTH-1:0]  cap_q
`endif
);

  op_e              op;
  logic [WIDTH-1:0] q_next;
  logic             ovf_set;
  logic             unf_set;
  logic             step_nz;

  assign step_nz = (step != '0);

  // A zero step or simultaneous incr/decr is a plain hold and raises no flags.
  always_comb begin
    op = OP_HOLD;
    if (ld) begin
      op = OP_LOAD;
    end else if (en && incr && !decr && step_nz) begin
      op = OP_UP;
    end else if (en && decr && !incr && step_nz) begin
      op = OP_DOWN;
    end
  end

  udcnt_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .q        (q),
    .limit_q  (limit_q),
    .step     (step),
    .op       (op),
    .mode_sat (mode_sat),
    .q_next   (q_next),
    .ovf_set  (ovf_set),
    .unf_set  (unf_set)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (op == OP_LOAD) begin
      q <= d;
    end else begin
      q <= q_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_q <= '1;
    end else if (limit_ld) begin
      limit_q <= limit_d;
    end
  end

  // A fresh event in the same cycle as flag_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~flag_clr);
      unf <= unf_set | (unf & ~flag_clr);
    end
  end

  assign tc_up = (q == limit_q);
  assign tc_dn = (q == '0);

`ifdef UDCNT_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else if (cap) begin
      cap_q <= q;
    end
  end
`endif

endmodule : ud_counter_sfr_gen

// File: tb/tb_ud_counter_sfr_gen.sv
// Directed bench for ud_counter_sfr_gen (WIDTH=8, STEP_W=4) with hand-computed
// expectations; capture checks are built only with UDCNT_CAPTURE_EN.
module tb_ud_counter_sfr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, ld, incr, decr, limit_ld, mode_sat, flag_clr;
  logic [7:0] d, limit_d;
  logic [3:0] step;
  logic [7:0] q, limit_q;
  logic       tc_up, tc_dn, ovf, unf;
`ifdef UDCNT_CAPTURE_EN
  logic       cap;
  logic [7:0] cap_q;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  ud_counter_sfr_gen #(
    .WIDTH     (8),
    .STEP_W    (4),
    .RESET_VAL (8'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld       (ld),
    .d        (d),
    .incr     (incr),
    .decr     (decr),
    .step     (step),
    .limit_ld (limit_ld),
    .limit_d  (limit_d),
    .mode_sat (mode_sat),
    .flag_clr (flag_clr),
    .q        (q),
    .limit_q  (limit_q),
    .tc_up    (tc_up),
    .tc_dn    (tc_dn),
    .ovf      (ovf),
    .unf      (unf)
`ifdef UDCNT_CAPTURE_EN
    ,
    .cap      (cap),
    .cap_q    (cap_q)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; ld = 1'b0; incr = 1'b0; decr = 1'b0; limit_ld = 1'b0;
    flag_clr = 1'b0; d = '0; limit_d = '0; step = '0;
`ifdef UDCNT_CAPTURE_EN
    cap = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    mode_sat = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_q", q, 0);
    chk("rst_limit", limit_q, 255);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_tc_dn", tc_dn, 1);
    chk("rst_tc_up", tc_up, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #4;

    // wrap up
    limit_ld = 1; limit_d = 8'd10; ld = 1; d = 8'd8;
    tick();
    chk("ld_q", q, 8);
    chk("ld_limit", limit_q, 10);
    en = 1; incr = 1; step = 4'd3; mode_sat = 1'b0;
    tick();
    chk("wrap_up_q", q, 0);
    chk("wrap_up_ovf", ovf, 1);
    chk("wrap_up_tc_dn", tc_dn, 1);
    flag_clr = 1;
    tick();
    chk("flag_clr_ovf", ovf, 0);

    // saturate down
    ld = 1; d = 8'd2;
    tick();
    en = 1; decr = 1; step = 4'd5; mode_sat = 1'b1;
    tick();
    chk("sat_dn_q", q, 0);
    chk("sat_dn_unf", unf, 1);
    en = 1; decr = 1; step = 4'd5;
    tick();
    chk("sat_dn2_q", q, 0);
    chk("sat_dn2_unf", unf, 1);

    // wrap down
    ld = 1; d = 8'd1; flag_clr = 1; mode_sat = 1'b0;
    tick();
    chk("wd_clr_unf", unf, 0);
    en = 1; decr = 1; step = 4'd2;
    tick();
    chk("wrap_dn_q", q, 10);
    chk("wrap_dn_tc_up", tc_up, 1);
    chk("wrap_dn_unf", unf, 1);

    // incr & decr together at the limit: hold, no ovf
    en = 1; incr = 1; decr = 1; step = 4'd3; flag_clr = 1;
    tick();
    chk("both_q", q, 10);
    chk("both_ovf", ovf, 0);
    chk("both_unf", unf, 0);
    en = 1; decr = 1; step = 4'd0;
    tick();
    chk("step0_q", q, 10);
    chk("step0_unf", unf, 0);

    // load above limit with en low
    ld = 1; d = 8'd200; en = 0; incr = 1; step = 4'd1;
    tick();
    chk("ld_over_q", q, 200);
    chk("ld_over_ovf", ovf, 0);
    limit_ld = 1; limit_d = 8'd100;
    tick();
    chk("limit100", limit_q, 100);
    en = 1; incr = 1; step = 4'd1;
    tick();
    chk("above_up_q", q, 0);
    chk("above_up_ovf", ovf, 1);

    // saturate at limit with flag_clr in the same cycle
    ld = 1; d = 8'd100;
    tick();
    en = 1; incr = 1; step = 4'd1; mode_sat = 1'b1; flag_clr = 1;
    tick();
    chk("sat_lim_q", q, 100);
    chk("sat_lim_ovf", ovf, 1);

    // down count from above the limit is ordinary
    ld = 1; d = 8'd150; flag_clr = 1; mode_sat = 1'b0;
    tick();
    en = 1; decr = 1; step = 4'd7;
    tick();
    chk("above_dn_q", q, 143);
    chk("above_dn_unf", unf, 0);
    chk("above_dn_ovf", ovf, 0);

    // new limit only applies after the edge that loads it
    ld = 1; d = 8'd19; limit_ld = 1; limit_d = 8'd255;
    tick();
    limit_ld = 1; limit_d = 8'd20; en = 1; incr = 1; step = 4'd4;
    tick();
    chk("oldlim_q", q, 23);
    chk("oldlim_ovf", ovf, 0);
    chk("oldlim_limit", limit_q, 20);
    en = 1; incr = 1; step = 4'd1;
    tick();
    chk("newlim_q", q, 0);
    chk("newlim_ovf", ovf, 1);

`ifdef UDCNT_CAPTURE_EN
    ld = 1; d = 8'd5;
    tick();
    cap = 1; en = 1; incr = 1; step = 4'd1;
    tick();
    chk("cap_q", cap_q, 5);
    chk("cap_cnt", q, 6);
    en = 1; incr = 1; step = 4'd1;
    tick();
    chk("cap_hold", cap_q, 5);
    chk("cap_cnt2", q, 7);
`endif

    // asynchronous reset mid-count
    ld = 1; d = 8'd40; limit_ld = 1; limit_d = 8'd60;
    tick();
    en = 1; incr = 1; step = 4'd2;
    #3 rst = 1'b1;
    #1;
    chk("arst_q", q, 0);
    chk("arst_limit", limit_q, 255);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    tick();
    chk("post_rst_q", q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ud_counter_sfr_gen
